mem_write_checker: RTL and testbench

Synthesizable self-check monitor for the multicycle MIPS data-memory write port. It watches `memwrite`/`dataadr`/`writedata` from the `top` and compares the write stream against a parametrised, ordered list of expected (address, data) pairs. It reports pass/fail with a failure code and timeout detection. It generalises the single "write 5 to address 92" bench check to N checkpoints, strict or relaxed matching, and on-chip use.

---
 rtl/mem_write_checker.sv | 106 ++++++++++
 tb/tb_mem_write_checker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks the data-memory write stream against an ordered list of expected (address, data) pairs
// Ports: clk, reset (async, active-low); start (run pulse), strict (unexpected-address fails);
//        memwrite/dataadr/writedata (processor write port); exp_addr/exp_data (packed entry lists);
//        busy/done/pass (status), fail_code (0 none, 1 data, 2 address, 3 timeout),
//        match_count (checkpoints matched), fail_addr/fail_data (write captured at failure)
module mem_write_checker #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CHECKS = 4,
    parameter int TIMEOUT = 1000,
    localparam int MW = $clog2(NUM_CHECKS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         strict,
    input  logic                         memwrite,
    input  logic [ADDR_W-1:0]            dataadr,
    input  logic [DATA_W-1:0]            writedata,
    input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   fail_code,
    output logic [MW-1:0]                match_count,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
    state_t state, state_d;
    logic [MW-1:0] mc_d;
    logic [TW-1:0] tcnt, tc_d;
    logic [1:0] fc_d;
    logic [ADDR_W-1:0] fa_d, cur_addr;
    logic [DATA_W-1:0] fd_d, cur_data;
    logic addr_hit, data_hit;
    assign busy = state == RUN;
    assign done = state == PASS || state == FAIL;
    assign pass = state == PASS;
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (match_count == MW'(i)) begin
                cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
                cur_data = exp_data[i*DATA_W +: DATA_W];
            end
        end
    end
    assign addr_hit = dataadr == cur_addr;
    assign data_hit = writedata == cur_data;
    always_comb begin
        state_d = state;
        mc_d = match_count;
        tc_d = tcnt;
        fc_d = fail_code;
        fa_d = fail_addr;
        fd_d = fail_data;
        if (start) begin
            state_d = RUN;
            mc_d = '0;
            tc_d = '0;
            fc_d = 2'd0;
            fa_d = '0;
            fd_d = '0;
        end else if (state == RUN) begin
            tc_d = (tcnt == '1) ? tcnt : tcnt + 1'b1;
            if (memwrite && addr_hit && data_hit) begin
                mc_d = match_count + 1'b1;
                state_d = (match_count == MW'(NUM_CHECKS - 1)) ? PASS : RUN;
            end else if (memwrite && (addr_hit || strict)) begin
                state_d = FAIL;
                fc_d = addr_hit ? 2'd1 : 2'd2;
                fa_d = dataadr;
                fd_d = writedata;
            end
            // a write decided on this edge outranks the timeout
            if (state_d == RUN && TIMEOUT != 0 && tcnt == TLAST) begin
                state_d = FAIL;
                fc_d = 2'd3;
                fa_d = '0;
                fd_d = '0;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            match_count <= '0;
            tcnt <= '0;
            fail_code <= 2'd0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state <= state_d;
            match_count <= mc_d;
            tcnt <= tc_d;
            fail_code <= fc_d;
            fail_addr <= fa_d;
            fail_data <= fd_d;
        end
    end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed vectors and multi-cycle sequences for mem_write_checker
module tb_mem_write_checker;
    logic clk = 0, reset = 0, start = 0, strict = 0, memwrite = 0;
    logic [31:0] dataadr = 0, writedata = 0;
    logic b3, d3, p3, b1, d1, p1;
    logic [1:0] fc3, fc1, mc3;
    logic mc1;
    logic [31:0] fa3, fd3, fa1, fd1;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(3), .TIMEOUT(20)) u3 (
        .clk(clk), .reset(reset), .start(start), .strict(strict), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .exp_addr({32'd92, 32'd88, 32'd84}), .exp_data({32'd5, 32'd12, 32'd7}),
        .busy(b3), .done(d3), .pass(p3), .fail_code(fc3), .match_count(mc3),
        .fail_addr(fa3), .fail_data(fd3));

    mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(1), .TIMEOUT(20)) u1 (
        .clk(clk), .reset(reset), .start(start), .strict(strict), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .exp_addr(32'd92), .exp_data(32'd5),
        .busy(b1), .done(d1), .pass(p1), .fail_code(fc1), .match_count(mc1),
        .fail_addr(fa1), .fail_data(fd1));

    typedef struct {
        logic st, sr, mw;
        logic [31:0] a, d;
        logic bz, dn, ps;
        logic [1:0] fc, mc;
        logic [31:0] fa, fd;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic st, sr, mw, input logic [31:0] a, d,
                                input logic bz, dn, ps, input logic [1:0] fc, mc,
                                input logic [31:0] fa, fd);
        vec_t v;
        v.st = st; v.sr = sr; v.mw = mw; v.a = a; v.d = d;
        v.bz = bz; v.dn = dn; v.ps = ps; v.fc = fc; v.mc = mc; v.fa = fa; v.fd = fd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic mw, input logic [31:0] a, input logic [31:0] d);
        start = st;
        memwrite = mw;
        dataadr = a;
        writedata = d;
    endtask

    initial begin
        int n;
        tbl[0]  = mk(1, 0, 1, 80, 1,  1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 80, 1,  1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 84, 7,  1, 0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 1, 88, 12, 1, 0, 0, 0, 2, 0, 0);
        tbl[4]  = mk(0, 0, 1, 60, 3,  1, 0, 0, 0, 2, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 2, 0, 0);
        tbl[6]  = mk(0, 0, 1, 92, 5,  0, 1, 1, 0, 3, 0, 0);
        tbl[7]  = mk(0, 0, 1, 92, 5,  0, 1, 1, 0, 3, 0, 0);
        tbl[8]  = mk(1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 1, 80, 1,  0, 1, 0, 2, 0, 80, 1);
        tbl[10] = mk(0, 1, 1, 84, 7,  0, 1, 0, 2, 0, 80, 1);
        tbl[11] = mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 84, 9,  0, 1, 0, 1, 0, 84, 9);
        tbl[13] = mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 84, 7,  1, 0, 0, 0, 1, 0, 0);
        tbl[15] = mk(0, 0, 1, 88, 12, 1, 0, 0, 0, 2, 0, 0);
        tbl[16] = mk(0, 0, 1, 92, 6,  0, 1, 0, 1, 2, 92, 6);

        #2;
        chk("rst_busy", b3, 0); chk("rst_done", d3, 0); chk("rst_pass", p3, 0);
        chk("rst_code", fc3, 0); chk("rst_mc", mc3, 0); chk("rst_fa", fa3, 0); chk("rst_fd", fd3, 0);
        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 17; i++) begin
            strict = tbl[i].sr;
            drive(tbl[i].st, tbl[i].mw, tbl[i].a, tbl[i].d);
            tick();
            chk($sformatf("v%0d_busy", i), b3, tbl[i].bz);
            chk($sformatf("v%0d_done", i), d3, tbl[i].dn);
            chk($sformatf("v%0d_pass", i), p3, tbl[i].ps);
            chk($sformatf("v%0d_code", i), fc3, tbl[i].fc);
            chk($sformatf("v%0d_mc", i), mc3, tbl[i].mc);
            chk($sformatf("v%0d_fa", i), fa3, tbl[i].fa);
            chk($sformatf("v%0d_fd", i), fd3, tbl[i].fd);
        end
        strict = 0;

        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0);
        repeat (10) tick();
        chk("single_wait_pass", p1, 0);
        drive(0, 1, 92, 5); tick();
        chk("single_pass", p1, 1); chk("single_done", d1, 1);
        chk("single_mc", mc1, 1); chk("single_code", fc1, 0);

        drive(1, 0, 0, 0); tick();
        drive(0, 1, 92, 6); tick();
        chk("dm_done", d1, 1); chk("dm_pass", p1, 0); chk("dm_code", fc1, 1);
        chk("dm_fa", fa1, 92); chk("dm_fd", fd1, 6);
        drive(1, 0, 0, 0); tick();
        chk("rs_busy", b1, 1); chk("rs_code", fc1, 0); chk("rs_fa", fa1, 0);
        chk("rs_fd", fd1, 0); chk("rs_mc", mc1, 0);
        drive(0, 1, 92, 5); tick();
        chk("rs_pass", p1, 1);

        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0);
        chk("to_busy", b1, 1);
        n = 0;
        while (!d1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", n, 20); chk("to_code", fc1, 3);
        chk("to_fa", fa1, 0); chk("to_fd", fd1, 0); chk("to_pass", p1, 0);

        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0);
        repeat (19) tick();
        chk("edge_busy", b1, 1);
        drive(0, 1, 92, 5); tick();
        chk("edge_pass", p1, 1); chk("edge_code", fc1, 0);

        drive(1, 0, 0, 0); tick();
        drive(0, 1, 84, 7); tick();
        drive(0, 1, 88, 12); tick();
        drive(0, 0, 0, 0);
        chk("pre_rst_mc", mc3, 2);
        #2 reset = 0;
        #1;
        chk("arst_busy", b3, 0); chk("arst_done", d3, 0); chk("arst_pass", p3, 0);
        chk("arst_code", fc3, 0); chk("arst_mc", mc3, 0); chk("arst_fa", fa3, 0); chk("arst_fd", fd3, 0);
        @(negedge clk);
        reset = 1;
        drive(0, 1, 92, 5); tick();
        chk("post_rst_busy1", b1, 0); chk("post_rst_pass1", p1, 0); chk("post_rst_mc1", mc1, 0);
        drive(0, 1, 84, 7); tick();
        chk("post_rst_busy3", b3, 0); chk("post_rst_mc3", mc3, 0);
        drive(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
